inv_sub_bytes_seq: RTL and testbench

Sequential AES inverse-substitution engine. It accepts one 128-bit cipher state and applies the FIPS-197 InvSubBytes table to every byte, two bytes (one 16-bit lane) per cycle. It returns the result over a valid/ready handshake. It sits on the decrypt path as the counterpart of the forward 16-bit S-box lookup stage.

---
 rtl/inv_sub_bytes_seq.sv | 87 ++++++++
 tb/tb_inv_sub_bytes_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: sequential AES InvSubBytes engine.
// Accepts one 128-bit state, substitutes one 16-bit lane (two bytes) per
// cycle through the FIPS-197 inverse S-box, and presents the finished block
// over a valid/ready handshake. wr doubles as the output register.
module inv_sub_bytes_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // FIPS-197 inverse S-box, entry k = InvS(k), rows of 16.
  localparam logic [7:0] INV_S [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  logic [1:0]   state;
  logic [2:0]   cnt;
  logic [127:0] wr;
  logic [15:0]  lane_in;
  logic [15:0]  lane_out;

  // Current lane and its substitution; bytes within a lane are independent.
  assign lane_in  = wr[{cnt, 4'b0000} +: 16];
  assign lane_out = {INV_S[lane_in[15:8]], INV_S[lane_in[7:0]]};

  // Control and datapath: accept in IDLE, one lane per cycle in RUN, hold in DONE.
  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; wr is a plain register (not a memory), so it is reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      wr    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            wr    <= in_data;
            cnt   <= 3'd0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          wr[{cnt, 4'b0000} +: 16] <= lane_out;
          cnt <= cnt + 3'd1;  // wraps to 0 after lane 7
          if (cnt == 3'd7) state <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake and status outputs decode the state only.
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign out_data  = wr;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// tb_inv_sub_bytes_seq: self-checking bench for inv_sub_bytes_seq.
// The reference S-box is derived from GF(2^8) inversion plus the AES affine
// map; the inverse table is obtained by inverting that permutation.
module tb_inv_sub_bytes_seq;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];

  inv_sub_bytes_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int s);
    return (v << s) | (v >> (8 - s));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] b;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = b;
      inv_sbox[b] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model_inv(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_sbox[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] model_fwd(input logic [127:0] d);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox[d[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present d at a negedge, let the next posedge accept it, then drop in_valid.
  task automatic accept(input logic [127:0] d);
    @(negedge clk);
    check("in_ready_before_accept", 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();  // later changes must not affect the block
  endtask

  // From the negedge after the accept edge, count edges until out_valid.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int           lat;
    logic [127:0] d;
    logic [127:0] blk [3];
    int           acc_cyc [3];
    int           k;
    int           outs;
    int           cyc;
    logic         saw_valid;

    build_tables();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    check("reset_in_ready",  128'(in_ready),  128'd1);
    check("reset_out_valid", 128'(out_valid), 128'd0);
    check("reset_busy",      128'(busy),      128'd0);
    check("reset_out_data",  out_data,        128'd0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_flags", {125'd0, in_ready, out_valid, busy}, 128'b100);
      check("idle_data",  out_data, 128'd0);
    end

    // All-zero block with out_ready high.
    out_ready = 1'b1;
    accept(128'd0);
    check("run_busy", 128'(busy), 128'd1);
    wait_valid(lat);
    check("zero_latency", 128'(lat), 128'd8);
    check("zero_data", out_data, {16{8'h52}});
    @(negedge clk);
    check("valid_one_cycle", 128'(out_valid), 128'd0);

    // Anchor block: lane order and per-byte mapping.
    d = 128'h637c7716_ff010063_7c771600_01ff637c;
    accept(d);
    wait_valid(lat);
    check("anchor_latency", 128'(lat), 128'd8);
    check("anchor_data", out_data, 128'h000102ff_7d095200_0102ff52_097d0001);
    check("anchor_model", out_data, model_inv(d));

    // Backpressure with a competing in_valid during DONE.
    @(negedge clk);
    out_ready = 1'b0;
    d = rand128();
    accept(d);
    wait_valid(lat);
    check("bp_latency", 128'(lat), 128'd8);
    blk[0] = rand128();
    in_valid = 1'b1;
    in_data  = blk[0];
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_valid",    128'(out_valid), 128'd1);
      check("bp_in_ready", 128'(in_ready),  128'd0);
      check("bp_data",     out_data,        model_inv(d));
    end
    out_ready = 1'b1;
    @(posedge clk);  // handshake edge
    @(negedge clk);
    check("bp_after_hs_valid", 128'(out_valid), 128'd0);
    check("bp_after_hs_ready", 128'(in_ready),  128'd1);
    @(posedge clk);  // next accept, one cycle after handshake
    @(negedge clk);
    check("bp_next_accepted", 128'(busy), 128'd1);
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp_next_latency", 128'(lat), 128'd8);
    check("bp_next_data", out_data, model_inv(blk[0]));
    @(negedge clk);

    // Asynchronous reset after lane 3 is written.
    d = rand128();
    accept(d);  // now at negedge after E0
    for (int i = 0; i < 4; i++) @(negedge clk);  // after E4
    #2 rst = 1'b1;
    #1;
    check("abort_out_valid", 128'(out_valid), 128'd0);
    check("abort_busy",      128'(busy),      128'd0);
    check("abort_in_ready",  128'(in_ready),  128'd1);
    check("abort_out_data",  out_data,        128'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_valid", 128'(saw_valid), 128'd0);
    d = rand128();
    in_valid = 1'b1;
    in_data  = d;
    rst = 1'b0;  // released at a negedge; next posedge accepts
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rand128();
    wait_valid(lat);
    check("post_reset_latency", 128'(lat), 128'd8);
    check("post_reset_data", out_data, model_inv(d));
    @(negedge clk);

    // Back-to-back: in_valid and out_ready tied high, three random blocks.
    for (int i = 0; i < 3; i++) blk[i] = rand128();
    k = 0; outs = 0; cyc = 0;
    in_valid = 1'b1;
    while (cyc < 60 && (k < 3 || outs < 3)) begin
      @(negedge clk);
      cyc++;
      if (out_valid && outs < k) begin
        check("b2b_data", out_data, model_inv(blk[outs]));
        check("b2b_roundtrip", model_fwd(out_data), blk[outs]);
        outs++;
      end
      if (in_ready) begin
        if (k < 3) begin
          in_data = blk[k];
          acc_cyc[k] = cyc;
          k++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        in_data = rand128();
      end
    end
    check("b2b_outputs", 128'(outs), 128'd3);
    check("b2b_spacing_1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd10);
    check("b2b_spacing_2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
